// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares one single-port synchronous instruction RAM between the fetch stage
//   (reads) and the program loader (writes). After reset the core is held in
//   BOOT while the loader fills the RAM. ld_done then moves the block to RUN,
//   where fetch has priority and the loader is guaranteed a slot after at most
//   STARVE_MAX consecutive fetch grants.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch request and byte address
//   if_stall              fetch not granted this cycle (combinational)
//   if_rvalid/if_rdata    fetch data, one cycle after the grant
//   ld_valid/ld_addr/
//   ld_wdata/ld_ready     loader write handshake (0-cycle accept)
//   ld_done               pulse that ends BOOT
//   boot                  1 while in BOOT
//   addr_err              sticky out-of-range flag
//   mem_*                 RAM port, driven combinationally from the grant
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | loader owns the RAM, every fetch stalls
// ST_RUN  | fetch has priority, loader forced in after STARVE_MAX waits
module imem_port_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          DEPTH      = 64,
  parameter bit          BOOT_EN    = 1'b1,
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] NOP_WORD   = 32'h00000013,
  localparam int         IDX_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic              boot,
  output logic              addr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       rd_pend, nop_pend, addr_err_q;
  logic       fetch_gnt, ld_gnt, force_ld;
  logic       if_oor, ld_oor;
  logic       unused_low_bits;

  assign if_oor = |if_addr[ADDR_W-1:IDX_W+2];
  assign ld_oor = |ld_addr[ADDR_W-1:IDX_W+2];
  assign unused_low_bits = ^{if_addr[1:0], ld_addr[1:0]};

  always_comb begin
    state_nxt  = state;
    fetch_gnt  = 1'b0;
    ld_ready   = 1'b0;
    force_ld   = 1'b0;
    if (!reset) begin
      case (state)
        ST_BOOT: begin
          ld_ready = 1'b1;
          if (ld_done) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          force_ld  = (starve_cnt == STARVE_LIM) && ld_valid;
          fetch_gnt = if_req && !force_ld;
          ld_ready  = !if_req || force_ld;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    ld_gnt   = ld_valid && ld_ready;
    if_stall = if_req && !fetch_gnt;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt && !if_oor) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[IDX_W+1:2];
    end else if (ld_gnt && !ld_oor) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr[IDX_W+1:2];
      mem_wdata = ld_wdata;
    end

    // A waiting loader accumulates fetch grants; any loader grant or an idle
    // loader clears the count.
    if (ld_gnt || !ld_valid) begin
      starve_nxt = '0;
    end else if (fetch_gnt && starve_cnt != STARVE_LIM) begin
      starve_nxt = starve_cnt + 4'd1;
    end else begin
      starve_nxt = starve_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT_EN ? ST_BOOT : ST_RUN;
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      nop_pend   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      rd_pend    <= fetch_gnt && !if_oor;
      nop_pend   <= fetch_gnt && if_oor;
      if ((fetch_gnt && if_oor) || (ld_gnt && ld_oor)) addr_err_q <= 1'b1;
    end
  end

  // The pending flags are gated by reset so a read in flight when reset
  // arrives is dropped in the reset cycle itself, not one cycle later.
  always_comb begin
    if_rvalid = (rd_pend || nop_pend) && !reset;
    if_rdata  = '0;
    if (!reset) begin
      if (rd_pend)       if_rdata = mem_rdata;
      else if (nop_pend) if_rdata = NOP_WORD;
    end
  end

  assign boot     = (state == ST_BOOT);
  assign addr_err = addr_err_q;

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Sequences and shares one single-port synchronous instruction RAM between two requesters: the pipeline fetch stage (read-only) and the program loader (write-only).
- After reset the block holds the core in a BOOT phase while the loader fills the RAM, then switches to RUN.
- In RUN, fetch has priority and the loader gets bounded-latency slots.
- Sits between the IF stage and the instruction RAM; drives the fetch stall into the hazard logic.

Parameters:
- ADDR_W, 32, byte-address width of fetch and loader addresses.
- DEPTH, 64, RAM depth in 32-bit words (power of two); index width IDX_W = clog2(DEPTH).
- BOOT_EN, 1, 1 = start in BOOT after reset; 0 = start directly in RUN.
- STARVE_MAX, 4, max consecutive fetch grants while a loader request waits before the loader is forced a slot (1..15).
- NOP_WORD, 32'h00000013, word returned for out-of-range fetches.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request this cycle.
- if_addr  in  ADDR_W  fetch byte address (bits [1:0] ignored).
- if_stall  out  1  combinational; 1 when if_req=1 and fetch is not granted this cycle.
- if_rvalid  out  1  registered; read data valid, exactly 1 cycle after the fetch grant.
- if_rdata  out  32  instruction word; valid only when if_rvalid=1.
- ld_valid  in  1  loader write request.
- ld_addr  in  ADDR_W  loader byte address (bits [1:0] ignored).
- ld_wdata  in  32  loader write data.
- ld_ready  out  1  combinational; write accepted this cycle when ld_valid & ld_ready.
- ld_done  in  1  single-cycle pulse ending BOOT.
- boot  out  1  registered; 1 while in BOOT.
- addr_err  out  1  sticky; set on any out-of-range fetch or loader write; cleared only by reset.
- mem_en  out  1  RAM port enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  IDX_W  RAM word index.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid 1 cycle after mem_en=1 & mem_we=0.

Behaviour:
- Reset values:
  - state = BOOT if BOOT_EN else RUN; boot matches the state.
  - if_rvalid=0, if_rdata=0, addr_err=0, starve counter=0, pending-read flags=0.
  - mem_* are combinational from the grant, so all read 0 while reset=1.
  - While reset=1 nothing is granted: ld_ready=0; if_stall=if_req.
- Word index = addr[IDX_W+1:2].
  - An address is out of range if any bit addr[ADDR_W-1:IDX_W+2] is set.
- BOOT state:
  - Loader is the only requester: ld_ready = 1; if_stall = if_req.
  - ld_done=1 moves to RUN next cycle. A write presented in the same cycle as ld_done is still accepted.
- RUN state, one grant per cycle:
  - Fetch is granted if if_req=1, unless the starve counter equals STARVE_MAX and ld_valid=1; in that case the loader is granted and the fetch stalls.
  - The loader is granted whenever if_req=0.
  - Starve counter:
    - Increments (saturating at STARVE_MAX) on each fetch grant while ld_valid=1.
    - Resets to 0 on a loader grant or when ld_valid=0.
- Fetch read grant:
  - If in range: mem_en=1, mem_we=0, mem_addr = index.
  - Next cycle: if_rvalid=1, if_rdata = mem_rdata.
  - If out of range: no RAM access; next cycle if_rvalid=1, if_rdata=NOP_WORD; addr_err is set.
- Loader write grant:
  - If in range: mem_en=1, mem_we=1, mem_wdata=ld_wdata.
  - If out of range: the handshake completes but the RAM is not written; addr_err is set.
- Latency:
  - Fetch: 1 cycle grant-to-data; back-to-back grants give 1 word per cycle.
  - Loader: 0-cycle accept when granted.
- Same-address write then read:
  - A write in cycle N followed by a fetch of that index in N+1 returns the new data.
  - RAM write-first is not required, since the accesses are in separate cycles.
- A reset asserted while a read is outstanding forces if_rvalid=0 on the next cycle; the data is dropped.
- ld_done in RUN is ignored.
- Only reset re-enters BOOT.

Test Plan:
- Reset with BOOT_EN=1: boot=1, if_rvalid=0, addr_err=0. Loader writes 0x00500093 @0x0 and 0x00308113 @0x4, then pulses ld_done -> boot=0 next cycle. Fetch @0x0 gives if_rvalid one cycle later with 0x00500093; fetch @0x4 gives 0x00308113.
- In BOOT, if_req=1 for 5 cycles -> if_stall=1 every cycle, mem_we=1 only on loader handshakes, if_rvalid stays 0.
- RUN, STARVE_MAX=4, if_req and ld_valid held high -> grant pattern F,F,F,F,L repeating; ld_ready=1 exactly on the 5th cycle; if_stall=1 in that same cycle.
- Fetch @0x400 with DEPTH=64 -> mem_en=0, next cycle if_rvalid=1 and if_rdata=0x00000013, addr_err=1 and sticky. Loader write @0x100 -> ld_ready=1, mem_we=0.
- Write 0xDEADBEEF @0x8 in cycle N, fetch @0x8 in N+1 -> if_rdata=0xDEADBEEF in N+2.
- Fetch granted in cycle N, reset asserted in N+1 -> if_rvalid=0 in N+1 and N+2; boot=1 after reset.
